// File: rtl/axi_ram_controller.sv
// AXI4-Lite responder bridging one bus port to a byte-strobed single-port RAM, one transaction at a time.
// Optional AXI_RAM_RANGE_CHECK_EN: out-of-window addresses answer SLVERR without touching the RAM.
`default_nettype none

module axi_ram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [31:0]                    awaddr,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     wstrb,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [1:0]                     bresp,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [31:0]                    araddr,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [31:0]                    rdata,
    output logic [1:0]                     rresp,
    output logic                           ram_req,
    output logic                           ram_we,
    output logic [$clog2(DEPTH_WORDS)-1:0] ram_addr,
    output logic [31:0]                    ram_wdata,
    output logic [3:0]                     ram_strb,
    input  logic [31:0]                    ram_rdata,
    input  logic                           ram_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ACC  = 3'd1,
        WR_RESP = 3'd2,
        RD_ACC  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t state, state_next;

    logic          read_first, read_first_next;
    logic          wr_pend, rd_pend, take_rd, take_wr;
    logic          wr_ok, rd_ok;
    logic [32:0]   wr_off, rd_off;
    logic [AW-1:0] addr_next;
    logic [31:0]   wdata_next, rdata_next;
    logic [3:0]    strb_next;
    logic [1:0]    bresp_next, rresp_next;

    // Bit 32 is the borrow: set when the address lies below BASE_ADDR.
    assign wr_off = {1'b0, awaddr} - {1'b0, BASE_ADDR};
    assign rd_off = {1'b0, araddr} - {1'b0, BASE_ADDR};

`ifdef AXI_RAM_RANGE_CHECK_EN
    assign wr_ok = !wr_off[32] && ((wr_off[31:0] >> (AW + 2)) == 32'd0);
    assign rd_ok = !rd_off[32] && ((rd_off[31:0] >> (AW + 2)) == 32'd0);
`else
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{wr_off[32], wr_off[31:AW+2], wr_off[1:0],
                           rd_off[32], rd_off[31:AW+2], rd_off[1:0]};

    assign wr_pend = awvalid && wvalid;
    assign rd_pend = arvalid;
    assign take_rd = (state == IDLE) && rd_pend && (!wr_pend || read_first);
    assign take_wr = (state == IDLE) && wr_pend && !take_rd;

    assign arready = take_rd;
    assign awready = take_wr;
    assign wready  = take_wr;

    always_comb begin
        state_next      = state;
        read_first_next = read_first;
        addr_next       = ram_addr;
        wdata_next      = ram_wdata;
        strb_next       = ram_strb;
        bresp_next      = bresp;
        rresp_next      = rresp;
        rdata_next      = rdata;
        case (state)
            IDLE: begin
                if (take_rd) begin
                    read_first_next = 1'b0;
                    addr_next       = rd_off[AW+1:2];
                    if (rd_ok) begin
                        rresp_next = 2'b00;
                        state_next = RD_ACC;
                    end else begin
                        rresp_next = 2'b10;
                        rdata_next = 32'h0000_0000;
                        state_next = RD_RESP;
                    end
                end else if (take_wr) begin
                    read_first_next = 1'b1;
                    addr_next       = wr_off[AW+1:2];
                    wdata_next      = wdata;
                    strb_next       = wstrb;
                    if (!wr_ok) begin
                        bresp_next = 2'b10;
                        state_next = WR_RESP;
                    end else begin
                        bresp_next = 2'b00;
                        // An all-zero strobe writes nothing, so the RAM is skipped.
                        state_next = (wstrb == 4'b0000) ? WR_RESP : WR_ACC;
                    end
                end
            end
            WR_ACC: begin
                if (ram_ready) state_next = WR_RESP;
            end
            RD_ACC: begin
                if (ram_ready) begin
                    rdata_next = ram_rdata;
                    state_next = RD_RESP;
                end
            end
            WR_RESP: begin
                if (bready) state_next = IDLE;
            end
            RD_RESP: begin
                if (rready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            read_first <= 1'b1;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 32'h0;
            ram_strb   <= 4'h0;
            bvalid     <= 1'b0;
            bresp      <= 2'b00;
            rvalid     <= 1'b0;
            rresp      <= 2'b00;
            rdata      <= 32'h0;
        end else begin
            state      <= state_next;
            read_first <= read_first_next;
            ram_req    <= (state_next == WR_ACC) || (state_next == RD_ACC);
            ram_we     <= (state_next == WR_ACC);
            ram_addr   <= addr_next;
            ram_wdata  <= wdata_next;
            ram_strb   <= strb_next;
            bvalid     <= (state_next == WR_RESP);
            bresp      <= bresp_next;
            rvalid     <= (state_next == RD_RESP);
            rresp      <= rresp_next;
            rdata      <= rdata_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_ram_controller.sv
// Randomized scoreboard bench for axi_ram_controller with a word-array reference model and a RAM model.
`default_nettype none

module tb_axi_ram_controller;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0]   awaddr = 0, wdata = 0, araddr = 0;
    logic [3:0]    wstrb = 0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic          ram_req, ram_we, ram_ready;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [3:0]    ram_strb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_ram_controller #(.BASE_ADDR(32'h0), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .nrst(nrst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_strb(ram_strb),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    // RAM model: ready after cur_stall wait cycles of a held request.
    logic [31:0] ram_mem [DEPTH];
    int cur_stall = 0;
    int wait_cnt  = 0;
    int req_seen  = 0;

    initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = 32'h0;

    assign ram_ready = ram_req && (wait_cnt >= cur_stall);
    assign ram_rdata = ram_mem[ram_addr];

    always @(posedge clk) begin
        if (ram_req) req_seen <= req_seen + 1;
        if (ram_req && !ram_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (ram_req && ram_ready && ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_strb[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    // Reference model: plain word array with byte merging.
    logic [31:0] model_mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    typedef struct {
        bit          is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    function automatic bit in_window(input logic [31:0] a);
`ifdef AXI_RAM_RANGE_CHECK_EN
        return a < 32'(4 * DEPTH);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        e.is_rd = 1'b0;
        e.data  = 32'h0;
        if (!in_window(a)) begin
            e.resp = 2'b10;
        end else begin
            e.resp = 2'b00;
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[word_of(a)][8*b +: 8] = d[8*b +: 8];
        end
        exp_q.push_back(e);
    endtask

    task automatic expect_read(input logic [31:0] a);
        exp_t e;
        e.is_rd = 1'b1;
        if (!in_window(a)) begin
            e.resp = 2'b10;
            e.data = 32'h0;
        end else begin
            e.resp = 2'b00;
            e.data = model_mem[word_of(a)];
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per completed response handshake.
    always @(negedge clk) begin
        if (nrst && ((bvalid && bready) || (rvalid && rready))) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {62'd0, bvalid, rvalid}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_rd)
                    check("rd_resp", {30'd0, rvalid && rready, rresp, rdata},
                          {30'd0, 1'b1, e.resp, e.data});
                else
                    check("wr_resp", {61'd0, bvalid && bready, bresp}, {61'd0, 1'b1, e.resp});
            end
        end
    end

    task automatic set_ready(input bit rd, input logic v);
        if (rd) rready = v;
        else bready = v;
    endtask

    task automatic wait_resp(input bit rd, input int dly);
        int n;
        n = 0;
        if (dly == 0) set_ready(rd, 1'b1);
        do begin
            @(negedge clk);
            n++;
        end while (!(rd ? rvalid : bvalid) && n < 200);
        if (n >= 200) check("resp_timeout", 64'd1, 64'd0);
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1 set_ready(rd, 1'b1);
        end
        @(posedge clk);
        #1 set_ready(rd, 1'b0);
    endtask

    task automatic wait_accept(input bit rd);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rd ? arready : (awready && wready)) && n < 200);
        if (n >= 200) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        if (rd) arvalid = 0;
        else begin
            awvalid = 0;
            wvalid  = 0;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int dly);
        expect_write(a, d, s);
        @(posedge clk);
        #1 awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        wait_accept(1'b0);
        wait_resp(1'b0, dly);
    endtask

    task automatic do_read(input logic [31:0] a, input int dly);
        expect_read(a);
        @(posedge clk);
        #1 araddr = a; arvalid = 1;
        wait_accept(1'b1);
        wait_resp(1'b1, dly);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 nrst = 0;
        @(negedge clk);
        check("reset_outputs",
              {28'd0, awready, wready, arready, bvalid, rvalid, ram_req, ram_we, ram_addr,
               bresp, rresp, ram_strb, 8'd0},
              64'd0);
        check("reset_data", {ram_wdata, rdata}, 64'd0);
        @(posedge clk);
        #1 nrst = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] hold_data;
        int req_before;

        apply_reset();

        // Word write with exact latency and RAM port contents.
        cur_stall = 0;
        expect_write(32'h20, 32'hABCD1234, 4'hF);
        @(posedge clk);
        #1 awaddr = 32'h20; wdata = 32'hABCD1234; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        @(negedge clk);
        check("wr_accept", {62'd0, awready, wready}, 64'd3);
        @(posedge clk);
        #1 awvalid = 0; wvalid = 0;
        @(negedge clk);
        check("wr_ram_port", {22'd0, ram_req, ram_we, ram_addr, ram_wdata, ram_strb},
              {22'd0, 1'b1, 1'b1, 4'd8, 32'hABCD1234, 4'hF});
        @(negedge clk);
        check("wr_bvalid_n2", {63'd0, bvalid}, 64'd1);
        @(posedge clk);
        #1 bready = 0;

        do_read(32'h20, 0);
        do_write(32'h22, 32'h56780000, 4'b1100, 1);
        do_read(32'h20, 2);

        // Simultaneous write and read straight after reset: read first.
        apply_reset();
        expect_read(32'h20);
        expect_write(32'h24, 32'hCAFEF00D, 4'hF);
        @(posedge clk);
        #1 araddr = 32'h20; arvalid = 1;
        awaddr = 32'h24; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        rready = 1; bready = 1;
        @(negedge clk);
        check("arb_read_first", {61'd0, arready, awready, wready}, 64'd4);
        @(posedge clk);
        #1 arvalid = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (awready) check("aw_during_read", 64'd1, 64'd0);
        end while (!rvalid && n < 50);
        @(negedge clk);
        check("wr_accept_after_read", {62'd0, awready, wready}, 64'd3);
        @(posedge clk);
        #1 awvalid = 0; wvalid = 0; rready = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bvalid && n < 50);
        check("wr_after_read_done", {63'd0, bvalid}, 64'd1);
        @(posedge clk);
        #1 bready = 0;

        // Back-pressure: 3 RAM wait cycles then 4 cycles of rready low.
        cur_stall = 3;
        expect_read(32'h24);
        @(posedge clk);
        #1 araddr = 32'h24; arvalid = 1;
        @(negedge clk);
        check("bp_accept", {63'd0, arready}, 64'd1);
        @(posedge clk);
        #1 arvalid = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_req_hold", {58'd0, ram_req, ram_we, rvalid, ram_addr},
                  {58'd0, 1'b1, 1'b0, 1'b0, 4'd9});
        end
        @(negedge clk);
        check("bp_rvalid", {63'd0, rvalid}, 64'd1);
        hold_data = rdata;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_rdata_stable", {31'd0, rvalid, rdata}, {31'd0, 1'b1, hold_data});
        end
        @(posedge clk);
        #1 rready = 1;
        @(posedge clk);
        #1 rready = 0;
        cur_stall = 0;

        // Reset during WR_ACC discards the write.
        cur_stall = 6;
        @(posedge clk);
        #1 awaddr = 32'h20; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk);
        #1 awvalid = 0; wvalid = 0;
        @(negedge clk);
        check("mid_wr_req", {63'd0, ram_req}, 64'd1);
        #1 nrst = 0;
        #1 check("mid_wr_reset_drop", {62'd0, ram_req, bvalid}, 64'd0);
        @(posedge clk);
        #1 nrst = 1;
        cur_stall = 0;
        do_read(32'h20, 0);

        // Window boundary: 0x40 is one past the last word.
        do_write(32'h0, 32'h11223344, 4'hF, 0);
        req_before = req_seen;
        do_read(32'h40, 0);
`ifdef AXI_RAM_RANGE_CHECK_EN
        check("oor_no_req", 64'(req_seen - req_before), 64'd0);
`else
        check("alias_req", {63'd0, req_seen != req_before}, 64'd1);
`endif
        req_before = req_seen;
        do_write(32'h2C, 32'hFFFFFFFF, 4'h0, 0);
        check("zero_strb_no_req", 64'(req_seen - req_before), 64'd0);
        do_read(32'h2C, 0);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            logic [3:0]  s;
            cur_stall = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 32'h40 + $urandom_range(0, 191);
            else a = $urandom_range(0, 63);
            s = 4'($urandom_range(0, 15));
            if (a >= 32'h40 && s == 4'h0) s = 4'h1;
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, s, int'($urandom_range(0, 2)));
            else do_read(a, int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
